// File: rtl/score_keeper_pkg.sv
// Shared Pong match constants: FSM state encoding, score width and winner codes.
// Reused by the display and ball logic, so encodings here are fixed.
package score_keeper_pkg;

  localparam int unsigned SCORE_W = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StServe = 2'd1,
    StPlay  = 2'd2,
    StOver  = 2'd3
  } state_e;

  localparam logic [1:0] WINNER_NONE = 2'b00;
  localparam logic [1:0] WINNER_P1   = 2'b01;
  localparam logic [1:0] WINNER_P2   = 2'b10;

  // Winner code for the player who just reached the winning score.
  function automatic logic [1:0] winner_code(input logic is_p2);
    return is_p2 ? WINNER_P2 : WINNER_P1;
  endfunction

endpackage

// File: rtl/score_keeper_edge_detect.sv
// 1-bit rising-edge detector: a level held high produces a single-cycle event.
module score_keeper_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic evt
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= din;
    end
  end

  assign evt = din & ~prev_q;

endmodule

// File: rtl/score_keeper.sv
// Pong match controller: counts goals, holds the ball for a fixed serve delay and
// detects the winner. All outputs are registered.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter logic [SCORE_W-1:0] WIN_SCORE   = 4'd10,
  parameter int unsigned        SERVE_DELAY = 100_000_000,
  parameter int unsigned        DLY_W       = 27
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               goal_p1,
  input  logic               goal_p2,
  input  logic               new_game,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               serve_en,
  output logic               game_over,
  output logic [1:0]         winner
);

  localparam logic [DLY_W-1:0] RELOAD = DLY_W'(SERVE_DELAY - 1);

  logic p1_evt, p2_evt, ng_evt;

  state_e             state_q, state_d;
  logic [DLY_W-1:0]   cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_p1_q, score_p1_d;
  logic [SCORE_W-1:0] score_p2_q, score_p2_d;
  logic [1:0]         winner_q, winner_d;
  logic               serve_en_q, serve_en_d;
  logic               game_over_q, game_over_d;

  score_keeper_edge_detect u_edge_p1 (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (goal_p1),
    .evt   (p1_evt)
  );

  score_keeper_edge_detect u_edge_p2 (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (goal_p2),
    .evt   (p2_evt)
  );

  score_keeper_edge_detect u_edge_ng (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (new_game),
    .evt   (ng_evt)
  );

  // State register and all registered datapath/outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      winner_q    <= WINNER_NONE;
      serve_en_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      winner_q    <= winner_d;
      serve_en_q  <= serve_en_d;
      game_over_q <= game_over_d;
    end
  end

  // Next state; new_game outranks any same-cycle goal in every state.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    score_p1_d = score_p1_q;
    score_p2_d = score_p2_q;
    winner_d   = winner_q;

    if (ng_evt) begin
      state_d    = StServe;
      cnt_d      = RELOAD;
      score_p1_d = '0;
      score_p2_d = '0;
      winner_d   = WINNER_NONE;
    end else begin
      case (state_q)
        StIdle: ;
        StServe: begin
          if (cnt_q == '0) begin
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        StPlay: begin
          if (p1_evt && p2_evt) begin
            // Simultaneous goals are a replay, not a point.
            state_d = StServe;
            cnt_d   = RELOAD;
          end else if (p1_evt) begin
            score_p1_d = score_p1_q + 1'b1;
            if (score_p1_d == WIN_SCORE) begin
              state_d  = StOver;
              winner_d = winner_code(1'b0);
            end else begin
              state_d = StServe;
              cnt_d   = RELOAD;
            end
          end else if (p2_evt) begin
            score_p2_d = score_p2_q + 1'b1;
            if (score_p2_d == WIN_SCORE) begin
              state_d  = StOver;
              winner_d = winner_code(1'b1);
            end else begin
              state_d = StServe;
              cnt_d   = RELOAD;
            end
          end
        end
        StOver: ;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs follow the state being entered so they line up with it after the edge.
  always_comb begin
    serve_en_d  = (state_d == StPlay);
    game_over_d = (state_d == StOver);
  end

  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;
  assign winner    = winner_q;
  assign serve_en  = serve_en_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed match scenarios followed by randomized play, checked against a
// cycle-level behavioural model of the match rules.
module tb_score_keeper;

  localparam int unsigned SD = 4;
  localparam int unsigned WS = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       goal_p1 = 1'b0;
  logic       goal_p2 = 1'b0;
  logic       new_game = 1'b0;
  logic [3:0] score_p1, score_p2;
  logic       serve_en, game_over;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;

  // Behavioural model: a match is active after new_game; serve_left counts the
  // held cycles still to go before the ball is released.
  int m_s1, m_s2, m_win, m_left;
  bit m_active, m_over;
  bit m_p1, m_p2, m_png;

  score_keeper #(
    .WIN_SCORE   (4'd3),
    .SERVE_DELAY (SD),
    .DLY_W       (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .goal_p1   (goal_p1),
    .goal_p2   (goal_p2),
    .new_game  (new_game),
    .score_p1  (score_p1),
    .score_p2  (score_p2),
    .serve_en  (serve_en),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_win = 0; m_left = 0;
    m_active = 1'b0; m_over = 1'b0;
    m_p1 = 1'b0; m_p2 = 1'b0; m_png = 1'b0;
  endtask

  task automatic model_step(input bit g1, input bit g2, input bit ng);
    bit r1, r2, rn;
    r1 = g1 && !m_p1;
    r2 = g2 && !m_p2;
    rn = ng && !m_png;
    m_p1 = g1; m_p2 = g2; m_png = ng;
    if (rn) begin
      m_s1 = 0; m_s2 = 0; m_win = 0; m_over = 1'b0;
      m_active = 1'b1; m_left = SD;
    end else if (m_active && !m_over) begin
      if (m_left > 0) begin
        m_left--;
      end else if (r1 && r2) begin
        m_left = SD;
      end else if (r1 || r2) begin
        if (r1) m_s1++; else m_s2++;
        if (m_s1 == WS) begin
          m_over = 1'b1; m_win = 1;
        end else if (m_s2 == WS) begin
          m_over = 1'b1; m_win = 2;
        end else begin
          m_left = SD;
        end
      end
    end
  endtask

  task automatic compare_model();
    check_eq("score_p1", score_p1, m_s1);
    check_eq("score_p2", score_p2, m_s2);
    check_eq("serve_en", serve_en, m_active && !m_over && m_left == 0);
    check_eq("game_over", game_over, m_over);
    check_eq("winner", winner, m_win);
  endtask

  // One clock: compare on the falling edge, then drive the inputs for the next rise.
  task automatic cycle(input bit g1, input bit g2, input bit ng);
    @(negedge clk);
    compare_model();
    rst_n    = 1'b1;
    goal_p1  = g1;
    goal_p2  = g2;
    new_game = ng;
    model_step(g1, g2, ng);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    model_reset();
    #12;
    check_eq("rst_score_p1", score_p1, 0);
    check_eq("rst_serve_en", serve_en, 0);
    check_eq("rst_winner", winner, 0);

    // Serve delay, goals ignored while serving.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b0);
    after_edge();
    check_eq("t2_held", serve_en, 0);
    cycle(1'b0, 1'b0, 1'b0);
    after_edge();
    check_eq("t2_serve_en", serve_en, 1);
    check_eq("t2_scores", {score_p1, score_p2}, 0);

    // Held goal counts once.
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b0);
    after_edge();
    check_eq("t3_score_p1", score_p1, 1);

    // Simultaneous goals: no point, back to serve.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0);
    after_edge();
    check_eq("t4_serve_en", serve_en, 0);
    check_eq("t4_scores", {score_p1, score_p2}, 8'h10);
    idle(4);

    // P2 wins, later goals ignored.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0);
      idle(4);
    end
    after_edge();
    check_eq("t5_score_p2", score_p2, 3);
    check_eq("t5_winner", winner, 2);
    check_eq("t5_game_over", game_over, 1);
    cycle(1'b0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    idle(2);
    after_edge();
    check_eq("t5_hold_scores", {score_p1, score_p2}, 8'h13);

    // new_game beats a same-cycle goal in OVER.
    cycle(1'b1, 1'b0, 1'b1);
    after_edge();
    check_eq("t6_scores", {score_p1, score_p2}, 0);
    check_eq("t6_winner", winner, 0);
    check_eq("t6_game_over", game_over, 0);
    check_eq("t6_serve_en", serve_en, 0);
    idle(4);

    // Reach 2/1 in PLAY, then reset asynchronously.
    cycle(1'b1, 1'b0, 1'b0); idle(4);
    cycle(1'b1, 1'b0, 1'b0); idle(4);
    cycle(1'b0, 1'b1, 1'b0); idle(4);
    after_edge();
    check_eq("t1_pre_scores", {score_p1, score_p2}, 8'h21);
    check_eq("t1_pre_serve_en", serve_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("t1_scores", {score_p1, score_p2}, 0);
    check_eq("t1_serve_en", serve_en, 0);
    compare_model();

    // Randomized play with occasional mid-match resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_model();
      end
      cycle($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 59) == 0);
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
